// File: rtl/hpdmc_wrseq_pkg.sv
// Shared definitions for the DDR16 write-data sequencer.
//   wr_state_t  : burst phase state (IDLE/PRE/DATA/POST)
//   DQS_*       : {D0,D1} patterns for the DQS DDR output cell
//   mask_width  : width of the write mask for a given DQ width
package hpdmc_wrseq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    POST
  } wr_state_t;

  localparam logic [1:0] DQS_IDLE   = 2'b00;
  localparam logic [1:0] DQS_TOGGLE = 2'b10;

  // One mask bit per byte, for both the rising and falling halves.
  function automatic int unsigned mask_width(input int unsigned dq_width);
    return dq_width / 4;
  endfunction

endpackage

// File: rtl/hpdmc_wrlat_pipe.sv
// Write-latency shift register for accepted write commands.
//   clk, rst_n  : clock, asynchronous active-low clear
//   accept      : a write command is accepted this cycle
//   start_due   : the preamble cycle of an accepted command is the current cycle
//   start_next  : the preamble cycle of an accepted command is the next cycle
//   pending     : any command still travelling through the pipe
module hpdmc_wrlat_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  output logic start_due,
  output logic start_next,
  output logic pending
);

  logic [DEPTH-1:0] sr;

  // start_next taps one stage earlier so the registered phase outputs
  // of the sequencer land exactly on the preamble cycle.
  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= accept;
      end
      assign start_next = accept;
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[DEPTH-2:0], accept};
      end
      assign start_next = sr[DEPTH-2];
    end
  endgenerate

  assign start_due = sr[DEPTH-1];
  assign pending   = |sr;

endmodule

// File: rtl/hpdmc_ddr_wrseq.sv
// Write-data sequencer for the DDR16 SDRAM PHY.
// Accepts write commands, then drives the D0/D1 inputs and output enables
// of the DQ/DM/DQS DDR cells with latency, preamble, data burst and
// postamble. Back-to-back commands merge into a gapless DQS stream.
//   sys_clk, sys_rst_n        : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready     : write command handshake
//   wd_valid / wd_data /
//   wd_mask / wd_ready        : write data handshake (low half = rising edge)
//   dq_d0/dq_d1, dm_d0/dm_d1  : DQ and DM DDR cell data inputs
//   dqs_d0/dqs_d1             : DQS DDR cell data inputs
//   dqs_oe, dq_oe             : DQS and DQ/DM tristate enables
//   busy                      : command pending or burst phase active
//   underrun                  : sticky, a data slot had no valid data
module hpdmc_ddr_wrseq
  import hpdmc_wrseq_pkg::*;
#(
  parameter int unsigned DQ_WIDTH      = 16,
  parameter int unsigned BURST_WORDS   = 4,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            wd_valid,
  input  logic [2*DQ_WIDTH-1:0]           wd_data,
  input  logic [mask_width(DQ_WIDTH)-1:0] wd_mask,
  output logic                            wd_ready,
  output logic [DQ_WIDTH-1:0]             dq_d0,
  output logic [DQ_WIDTH-1:0]             dq_d1,
  output logic [DQ_WIDTH/8-1:0]           dm_d0,
  output logic [DQ_WIDTH/8-1:0]           dm_d1,
  output logic                            dqs_d0,
  output logic                            dqs_d1,
  output logic                            dqs_oe,
  output logic                            dq_oe,
  output logic                            busy,
  output logic                            underrun
);

  localparam int unsigned HALF_MASK = DQ_WIDTH / 8;
  localparam int unsigned MASK_W    = mask_width(DQ_WIDTH);
  localparam int unsigned BEAT_W    = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int unsigned CD_W      = $clog2(BURST_WORDS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_WORDS - 1);

  logic            accept;
  logic            start_due;
  logic            start_next;
  logic            pipe_pending;

  wr_state_t       state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CD_W-1:0] cd_q, cd_d;

  assign accept = cmd_valid && cmd_ready;

  hpdmc_wrlat_pipe #(
    .DEPTH (WRITE_LATENCY)
  ) u_lat (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .accept     (accept),
    .start_due  (start_due),
    .start_next (start_next),
    .pending    (pipe_pending)
  );

  // Command spacing: cmd_ready stays low for BURST_WORDS-1 cycles after
  // each accept.
  always_comb begin
    cd_d = cd_q;
    if (accept)
      cd_d = CD_W'(BURST_WORDS - 1);
    else if (cd_q != '0)
      cd_d = cd_q - CD_W'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cd_q      <= '0;
      cmd_ready <= 1'b0;
    end else begin
      cd_q      <= cd_d;
      cmd_ready <= (cd_d == '0);
    end
  end

  // state_q is the phase currently shown on the DDR cells. start_due
  // means a new command's preamble falls in this very cycle, so on the
  // last beat (or in POST) it continues straight into data.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (start_next) begin
          state_d = PRE;
          beat_d  = '0;
        end
      end
      PRE: begin
        state_d = DATA;
        beat_d  = '0;
      end
      DATA: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = start_due ? DATA : POST;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      POST: begin
        beat_d = '0;
        if (start_due)       state_d = DATA;
        else if (start_next) state_d = PRE;
        else                 state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q          <= IDLE;
      beat_q           <= '0;
      dqs_oe           <= 1'b0;
      dq_oe            <= 1'b0;
      {dqs_d0, dqs_d1} <= DQS_IDLE;
    end else begin
      state_q          <= state_d;
      beat_q           <= beat_d;
      dqs_oe           <= (state_d != IDLE);
      dq_oe            <= (state_d == DATA);
      {dqs_d0, dqs_d1} <= (state_d == DATA) ? DQS_TOGGLE : DQS_IDLE;
    end
  end

  // Data is pulled one cycle ahead of each slot: the preamble cycle of a
  // command plus every data beat except the last.
  assign wd_ready = start_due || ((state_q == DATA) && (beat_q != LAST_BEAT));
  assign busy     = (state_q != IDLE) || pipe_pending;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dq_d0    <= '0;
      dq_d1    <= '0;
      dm_d0    <= '0;
      dm_d1    <= '0;
      underrun <= 1'b0;
    end else if (wd_ready) begin
      if (wd_valid) begin
        dq_d0 <= wd_data[DQ_WIDTH-1:0];
        dq_d1 <= wd_data[2*DQ_WIDTH-1:DQ_WIDTH];
        dm_d0 <= wd_mask[HALF_MASK-1:0];
        dm_d1 <= wd_mask[MASK_W-1:HALF_MASK];
      end else begin
        dq_d0    <= '0;
        dq_d1    <= '0;
        dm_d0    <= '1;
        dm_d1    <= '1;
        underrun <= 1'b1;
      end
    end else begin
      dq_d0 <= '0;
      dq_d1 <= '0;
      dm_d0 <= '0;
      dm_d1 <= '0;
    end
  end

endmodule

// File: tb/tb_hpdmc_ddr_wrseq.sv
module tb_hpdmc_ddr_wrseq;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        wd_valid;
  logic [31:0] wd_data;
  logic [3:0]  wd_mask;
  logic        wd_ready;
  logic [15:0] dq_d0, dq_d1;
  logic [1:0]  dm_d0, dm_d1;
  logic        dqs_d0, dqs_d1, dqs_oe, dq_oe, busy, underrun;

  int checks   = 0;
  int failures = 0;

  hpdmc_ddr_wrseq #(
    .DQ_WIDTH      (16),
    .BURST_WORDS   (4),
    .WRITE_LATENCY (1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .wd_valid  (wd_valid),
    .wd_data   (wd_data),
    .wd_mask   (wd_mask),
    .wd_ready  (wd_ready),
    .dq_d0     (dq_d0),
    .dq_d1     (dq_d1),
    .dm_d0     (dm_d0),
    .dm_d1     (dm_d1),
    .dqs_d0    (dqs_d0),
    .dqs_d1    (dqs_d1),
    .dqs_oe    (dqs_oe),
    .dq_oe     (dq_oe),
    .busy      (busy),
    .underrun  (underrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        cmd_ready;
    logic        wd_ready;
    logic        busy;
    logic        underrun;
    logic        dqs_oe;
    logic        dq_oe;
    logic        dqs_d0;
    logic        dqs_d1;
    logic [15:0] dq_d0;
    logic [15:0] dq_d1;
    logic [1:0]  dm_d0;
    logic [1:0]  dm_d1;
  } out_t;

  typedef struct {
    logic        cmd_valid;
    logic        wd_valid;
    logic [31:0] wd_data;
    logic [3:0]  wd_mask;
    out_t        exp;
  } vec_t;

  vec_t vecs[20];

  function automatic out_t mk(input logic cr, wr, bz, ur, so, qo, s0, s1,
                              input logic [15:0] q0, q1,
                              input logic [1:0] m0, m1);
    return {cr, wr, bz, ur, so, qo, s0, s1, q0, q1, m0, m1};
  endfunction

  function automatic out_t cur();
    return {cmd_ready, wd_ready, busy, underrun, dqs_oe, dq_oe, dqs_d0, dqs_d1,
            dq_d0, dq_d1, dm_d0, dm_d1};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, return at the
  // falling edge where outputs are sampled.
  task automatic cyc(input logic cv, input logic wv, input logic [31:0] d, input logic [3:0] m);
    @(posedge sys_clk);
    #1;
    cmd_valid = cv;
    wd_valid  = wv;
    wd_data   = d;
    wd_mask   = m;
    @(negedge sys_clk);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy; i++) cyc(1'b0, 1'b1, 32'h0, 4'h0);
    chk(name, {63'h0, busy}, 64'h0);
  endtask

  function automatic logic [31:0] sp_data(input int c);
    return {16'hE000 + 16'(c), 16'hF000 + 16'(c)};
  endfunction

  initial begin
    cmd_valid = 1'b0;
    wd_valid  = 1'b0;
    wd_data   = '0;
    wd_mask   = '0;
    sys_rst_n = 1'b0;

    // Single write (rows 0-7), then gapless pair with commands 4 apart (rows 8-19).
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        4'h0, mk(1,0,0,0,0,0,0,0,16'h0,16'h0,2'b00,2'b00)};
    vecs[1]  = '{1'b0, 1'b1, 32'h11112222, 4'h0, mk(0,1,1,0,1,0,0,0,16'h0,16'h0,2'b00,2'b00)};
    vecs[2]  = '{1'b0, 1'b1, 32'h33334444, 4'h1, mk(0,1,1,0,1,1,1,0,16'h2222,16'h1111,2'b00,2'b00)};
    vecs[3]  = '{1'b0, 1'b1, 32'h55556666, 4'h8, mk(0,1,1,0,1,1,1,0,16'h4444,16'h3333,2'b01,2'b00)};
    vecs[4]  = '{1'b0, 1'b1, 32'h77778888, 4'h0, mk(1,1,1,0,1,1,1,0,16'h6666,16'h5555,2'b00,2'b10)};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        4'h0, mk(1,0,1,0,1,1,1,0,16'h8888,16'h7777,2'b00,2'b00)};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        4'h0, mk(1,0,1,0,1,0,0,0,16'h0,16'h0,2'b00,2'b00)};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        4'h0, mk(1,0,0,0,0,0,0,0,16'h0,16'h0,2'b00,2'b00)};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        4'h0, mk(1,0,0,0,0,0,0,0,16'h0,16'h0,2'b00,2'b00)};
    vecs[9]  = '{1'b0, 1'b1, 32'h10012001, 4'h0, mk(0,1,1,0,1,0,0,0,16'h0,16'h0,2'b00,2'b00)};
    vecs[10] = '{1'b0, 1'b1, 32'h10022002, 4'h0, mk(0,1,1,0,1,1,1,0,16'h2001,16'h1001,2'b00,2'b00)};
    vecs[11] = '{1'b0, 1'b1, 32'h10032003, 4'h0, mk(0,1,1,0,1,1,1,0,16'h2002,16'h1002,2'b00,2'b00)};
    vecs[12] = '{1'b1, 1'b1, 32'h10042004, 4'h0, mk(1,1,1,0,1,1,1,0,16'h2003,16'h1003,2'b00,2'b00)};
    vecs[13] = '{1'b0, 1'b1, 32'h10052005, 4'h0, mk(0,1,1,0,1,1,1,0,16'h2004,16'h1004,2'b00,2'b00)};
    vecs[14] = '{1'b0, 1'b1, 32'h10062006, 4'h6, mk(0,1,1,0,1,1,1,0,16'h2005,16'h1005,2'b00,2'b00)};
    vecs[15] = '{1'b0, 1'b1, 32'h10072007, 4'h0, mk(0,1,1,0,1,1,1,0,16'h2006,16'h1006,2'b10,2'b01)};
    vecs[16] = '{1'b0, 1'b1, 32'h10082008, 4'h0, mk(1,1,1,0,1,1,1,0,16'h2007,16'h1007,2'b00,2'b00)};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        4'h0, mk(1,0,1,0,1,1,1,0,16'h2008,16'h1008,2'b00,2'b00)};
    vecs[18] = '{1'b0, 1'b0, 32'h0,        4'h0, mk(1,0,1,0,1,0,0,0,16'h0,16'h0,2'b00,2'b00)};
    vecs[19] = '{1'b0, 1'b0, 32'h0,        4'h0, mk(1,0,0,0,0,0,0,0,16'h0,16'h0,2'b00,2'b00)};

    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_state", cur(), 64'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    chk("released_before_edge", cur(), 64'h0);

    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].cmd_valid, vecs[i].wd_valid, vecs[i].wd_data, vecs[i].wd_mask);
      chk($sformatf("vec%0d", i), cur(), vecs[i].exp);
    end

    // Spacing 5: merged postamble/preamble cycle between the bursts.
    for (int c = 0; c <= 12; c++) begin
      cyc(c == 0 || c == 5, 1'b1, sp_data(c), 4'h0);
      if (c == 5)  chk("sp5_c5_last_beat", {59'h0, wd_ready, dqs_oe, dq_oe, dqs_d0, dqs_d1}, 64'b01110);
      if (c == 6)  chk("sp5_c6_merged",    {59'h0, wd_ready, dqs_oe, dq_oe, dqs_d0, dqs_d1}, 64'b11000);
      if (c == 7)  chk("sp5_c7_data",      {43'h0, dqs_oe, dq_oe, dqs_d0, dqs_d1, dq_d0}, {43'h0, 4'b1110, 16'hF006});
      if (c == 11) chk("sp5_c11_post",     {60'h0, dqs_oe, dq_oe, dqs_d0, dqs_d1}, 64'b1000);
      if (c == 12) chk("sp5_c12_idle",     {59'h0, busy, dqs_oe, dq_oe, dqs_d0, dqs_d1}, 64'h0);
    end

    // cmd_valid held high: accepts only every fourth cycle.
    for (int c = 0; c < 12; c++) begin
      cyc(1'b1, 1'b1, sp_data(c), 4'h0);
      chk($sformatf("hold_cmd_ready_c%0d", c), {63'h0, cmd_ready}, {63'h0, (c % 4) == 0});
    end
    wait_idle("hold_drain_idle");

    // Underrun on the second data slot.
    for (int c = 0; c <= 8; c++) begin
      cyc(c == 0, c != 2 && c >= 1 && c <= 4, {16'hC000 + 16'(c), 16'hD000 + 16'(c)}, 4'h0);
      if (c == 0) chk("ur_c0_cmd_ready", {63'h0, cmd_ready}, 64'h1);
      if (c == 2) chk("ur_c2", {47'h0, underrun, dq_d0}, {47'h0, 1'b0, 16'hD001});
      if (c == 3) chk("ur_c3_slot", {26'h0, dq_d0, dq_d1, dm_d0, dm_d1, underrun, dq_oe},
                      {26'h0, 16'h0, 16'h0, 2'b11, 2'b11, 1'b1, 1'b1});
      if (c == 4) chk("ur_c4", {43'h0, underrun, dm_d0, dm_d1, dq_d0}, {43'h0, 1'b1, 4'h0, 16'hD003});
      if (c == 5) chk("ur_c5", {46'h0, underrun, dq_oe, dq_d0}, {46'h0, 2'b11, 16'hD004});
      if (c == 8) chk("ur_c8_sticky", {62'h0, underrun, busy}, 64'b10);
    end

    // Reset in the middle of a burst.
    cyc(1'b1, 1'b0, 32'h0, 4'h0);
    cyc(1'b0, 1'b1, 32'h12345678, 4'h0);
    cyc(1'b0, 1'b1, 32'h23456789, 4'h0);
    cyc(1'b0, 1'b1, 32'h3456789A, 4'h0);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_burst", cur(), 64'h0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cyc(1'b1, 1'b1, 32'h0, 4'h0);
    chk("rst_after_release", cur(), mk(1,0,0,0,0,0,0,0,16'h0,16'h0,2'b00,2'b00));
    cyc(1'b0, 1'b1, 32'h9999AAAA, 4'h0);
    chk("rst_new_preamble", cur(), mk(0,1,1,0,1,0,0,0,16'h0,16'h0,2'b00,2'b00));
    cyc(1'b0, 1'b1, 32'h0, 4'h0);
    chk("rst_new_data", cur(), mk(0,1,1,0,1,1,1,0,16'hAAAA,16'h9999,2'b00,2'b00));
    wait_idle("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
